// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Package  : aes_pkg
// Brief    : Shared types, constants and inverse-round helpers for the
//            iterative AES inverse cipher.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [1:0] {
        MODE_128     = 2'b00,
        MODE_192     = 2'b01,
        MODE_256     = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    localparam logic [3:0] C_NR_128 = 4'd10;
    localparam logic [3:0] C_NR_192 = 4'd12;
    localparam logic [3:0] C_NR_256 = 4'd14;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] C_INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // Illegal mode runs the AES-128 schedule; the error flag travels separately.
    function automatic logic [3:0] nr_of(input logic [1:0] mode);
        case (mode)
            MODE_192: return C_NR_192;
            MODE_256: return C_NR_256;
            default:  return C_NR_128;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] b, input logic [3:0] m);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return (m[0] ? b : 8'h00) ^ (m[1] ? x2 : 8'h00) ^
               (m[2] ? x4 : 8'h00) ^ (m[3] ? x8 : 8'h00);
    endfunction

    // Byte k of the block sits at [127-8k -: 8]; state[r][c] is byte r+4c.
    function automatic block_t inv_shift_rows(input block_t s);
        block_t o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic block_t inv_sub_bytes(input block_t s);
        block_t o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127-8*i -: 8] = C_INV_SBOX[s[127-8*i -: 8]];
        end
        return o;
    endfunction

    function automatic block_t add_round_key(input block_t s, input block_t rk);
        return s ^ rk;
    endfunction

    function automatic block_t inv_mix_columns(input block_t s);
        block_t     o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
            o[119-32*c -: 8] = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
            o[111-32*c -: 8] = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
            o[103-32*c -: 8] = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_cipher_iter_if.sv
`default_nettype none
// ============================================================================
// Interface : aes_inv_cipher_iter_if
// Brief     : Job/result handshake bundle of the iterative inverse cipher.
// Revision  : 1.0 - initial release
// ============================================================================
interface aes_inv_cipher_iter_if
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 1920
);
    logic                i_valid;
    logic                i_ready;
    logic [1:0]          i_mode;
    block_t              i_data;
    logic [KEY_BITS-1:0] i_key;
    logic                o_valid;
    logic                o_ready;
    block_t              o_data;
    logic                o_err;

    modport master (
        output i_valid, i_mode, i_data, i_key, o_ready,
        input  i_ready, o_valid, o_data, o_err
    );

    modport slave (
        input  i_valid, i_mode, i_data, i_key, o_ready,
        output i_ready, o_valid, o_data, o_err
    );
endinterface
`default_nettype wire

// File: rtl/aes_inv_round.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_round
// Brief    : One combinational AES inverse round; final rounds skip
//            InvMixColumns.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_round
    import aes_pkg::*;
(
    input  wire block_t i_state,
    input  wire block_t i_rkey,
    input  wire         i_final,
    output block_t      o_state
);
    block_t w_sub;
    block_t w_ark;

    assign w_sub   = inv_sub_bytes(inv_shift_rows(i_state));
    assign w_ark   = add_round_key(w_sub, i_rkey);
    assign o_state = i_final ? w_ark : inv_mix_columns(w_ark);
endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_inv_cipher_iter
// Brief    : Iterative AES-128/192/256 inverse cipher, UNROLL rounds per clock.
// Revision : 1.0 - initial release
// ============================================================================
module aes_inv_cipher_iter
    import aes_pkg::*;
#(
    parameter int UNROLL   = 1,
    parameter int KEY_BITS = 1920
) (
    input wire                   clk,
    input wire                   rst_n,
    aes_inv_cipher_iter_if.slave bus
);
    localparam int         C_NUM_RK = KEY_BITS / 128;
    localparam logic [3:0] C_STEP   = 4'(UNROLL);

    if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
        $fatal(1, "aes_inv_cipher_iter: UNROLL must be 1 or 2");
    end

    state_e              r_state;
    logic [3:0]          r_round;
    logic                r_in_ready;
    logic                r_out_valid;
    logic                r_err_job;
    logic                r_err_out;
    block_t              r_data;
    block_t              r_block;
    logic [KEY_BITS-1:0] r_key;

    logic                w_accept;
    logic [3:0]          w_nr;
    block_t              w_last_rk;
    block_t              w_rk    [16];
    block_t              w_chain [UNROLL+1];

    assign w_accept  = bus.i_valid & r_in_ready;
    assign w_nr      = nr_of(bus.i_mode);
    assign w_last_rk = bus.i_key[KEY_BITS-1-128*int'(w_nr) -: 128];

    // Padded to 16 entries so a 4-bit index can never leave the array.
    for (genvar i = 0; i < 16; i++) begin : g_rk
        if (i < C_NUM_RK) begin : g_live
            assign w_rk[i] = r_key[KEY_BITS-1-128*i -: 128];
        end else begin : g_pad
            assign w_rk[i] = '0;
        end
    end

    assign w_chain[0] = r_block;

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [3:0] w_idx;
        assign w_idx = r_round - 4'(k);

        aes_inv_round u_round (
            .i_state (w_chain[k]),
            .i_rkey  (w_rk[w_idx]),
            .i_final (w_idx == 4'd0),
            .o_state (w_chain[k+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_round     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_err_job   <= 1'b0;
            r_err_out   <= 1'b0;
            r_data      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_round    <= w_nr - 4'd1;
                        r_err_job  <= (bus.i_mode == MODE_ILLEGAL);
                    end
                end
                ST_RUN: begin
                    // Nr is always even, so the last step lands exactly on round 0.
                    if (r_round < C_STEP) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_round     <= '0;
                        r_data      <= w_chain[UNROLL];
                        r_err_out   <= r_err_job;
                    end else begin
                        r_round <= r_round - C_STEP;
                    end
                end
                ST_DONE: begin
                    if (bus.o_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_block <= bus.i_data ^ w_last_rk;
            r_key   <= bus.i_key;
        end else if (r_state == ST_RUN) begin
            r_block <= w_chain[UNROLL];
        end
    end

    assign bus.i_ready = r_in_ready;
    assign bus.o_valid = r_out_valid;
    assign bus.o_data  = r_data;
    assign bus.o_err   = r_err_out;
endmodule
`default_nettype wire
